// File: rtl/axil_regbank.sv
// axil_regbank: AXI4-Lite slave register bank.
// N_RW read/write control registers (driven on rw_q) followed by N_RO
// read-only status words (sampled from ro_d) in one flat word-indexed map.
// Optional feature macro: AXIL_REGBANK_STRB_EN
//   defined   -> byte-lane merge of partial writes into read/write registers
//   undefined -> read/write registers accept only full-word writes (wstrb all
//                ones); partial writes are refused with SLVERR.
module axil_regbank #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 16,
    parameter int N_RW   = 8,
    parameter int N_RO   = 8,
    parameter logic [N_RW*DATA_W-1:0] RW_RST_VAL = '0
) (
    input  logic                                     axi_clk,
    input  logic                                     axi_rst,
    input  logic [ADDR_W-1:0]                        axi_awaddr,
    input  logic [2:0]                               axi_awprot,
    input  logic                                     axi_awvalid,
    output logic                                     axi_awready,
    input  logic [DATA_W-1:0]                        axi_wdata,
    input  logic [DATA_W/8-1:0]                      axi_wstrb,
    input  logic                                     axi_wvalid,
    output logic                                     axi_wready,
    output logic [1:0]                               axi_bresp,
    output logic                                     axi_bvalid,
    input  logic                                     axi_bready,
    input  logic [ADDR_W-1:0]                        axi_araddr,
    input  logic [2:0]                               axi_arprot,
    input  logic                                     axi_arvalid,
    output logic                                     axi_arready,
    output logic [DATA_W-1:0]                        axi_rdata,
    output logic [1:0]                               axi_rresp,
    output logic                                     axi_rvalid,
    input  logic                                     axi_rready,
    output logic [N_RW*DATA_W-1:0]                   rw_q,
    output logic [N_RW-1:0]                          wr_pulse,
    input  logic [((N_RO > 0) ? N_RO : 1)*DATA_W-1:0] ro_d,
    output logic [((N_RO > 0) ? N_RO : 1)-1:0]        rd_pulse
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int IDX_W  = ADDR_W - LSB;
    localparam int RO_W   = (N_RO > 0) ? N_RO : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // write channel state
    logic              aw_held_reg;
    logic              w_held_reg;
    logic              bvalid_reg;
    logic [1:0]        bresp_reg;
    logic [IDX_W-1:0]  aw_idx_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [STRB_W-1:0] wstrb_reg;

    // read channel state
    logic              rvalid_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic [1:0]        rresp_reg;
    logic [RO_W-1:0]   rd_pulse_reg;

    logic aw_hs, w_hs, b_hs, ar_hs;
    logic [31:0] w_idx, r_idx;
    logic w_is_rw, w_is_ro, r_is_rw, r_is_ro;
    logic wr_commit, wr_accept, wr_apply;
    logic [1:0] wr_resp_next;
    logic [DATA_W-1:0] wr_mask;
    logic [DATA_W-1:0] rd_data_next;
    logic [1:0]        rd_resp_next;
    logic [RO_W-1:0]   rd_pulse_next;

    // prot and the byte offset inside a word carry no meaning for this map
    logic unused_sigs;
    assign unused_sigs = ^{axi_awprot, axi_arprot, axi_awaddr[LSB-1:0], axi_araddr[LSB-1:0]};

    assign axi_awready = !aw_held_reg && !bvalid_reg;
    assign axi_wready  = !w_held_reg && !bvalid_reg;
    assign axi_arready = !rvalid_reg;
    assign axi_bvalid  = bvalid_reg;
    assign axi_bresp   = bresp_reg;
    assign axi_rvalid  = rvalid_reg;
    assign axi_rdata   = rdata_reg;
    assign axi_rresp   = rresp_reg;
    assign rd_pulse    = rd_pulse_reg;

    assign aw_hs = axi_awvalid && axi_awready;
    assign w_hs  = axi_wvalid && axi_wready;
    assign b_hs  = bvalid_reg && axi_bready;
    assign ar_hs = axi_arvalid && axi_arready;

    // word-index decode for the held write and the incoming read
    assign w_idx   = 32'(aw_idx_reg);
    assign r_idx   = 32'(axi_araddr[ADDR_W-1:LSB]);
    assign w_is_rw = w_idx < 32'(N_RW);
    assign w_is_ro = !w_is_rw && (w_idx < 32'(N_RW + N_RO));
    assign r_is_rw = r_idx < 32'(N_RW);
    assign r_is_ro = !r_is_rw && (r_idx < 32'(N_RW + N_RO));

    // commit happens on the first cycle both halves are held and no response is pending
    assign wr_commit = aw_held_reg && w_held_reg && !bvalid_reg;
`ifdef AXIL_REGBANK_STRB_EN
    assign wr_accept = w_is_rw;
`else
    assign wr_accept = w_is_rw && (&wstrb_reg);
`endif
    assign wr_apply = wr_commit && wr_accept;

    // response code for the write being committed
    always_comb begin
        wr_resp_next = RESP_DECERR;
        if (wr_accept)
            wr_resp_next = RESP_OKAY;
        else if (w_is_rw || w_is_ro)
            wr_resp_next = RESP_SLVERR;
    end

    // expand byte strobes into a bit mask
    for (genvar gi = 0; gi < STRB_W; gi++) begin : g_mask
        assign wr_mask[gi*8 +: 8] = {8{wstrb_reg[gi]}};
    end

    // one storage word and one commit strobe per read/write register
    for (genvar gi = 0; gi < N_RW; gi++) begin : g_rw
        logic [DATA_W-1:0] q_reg;
        logic              pulse_reg;
        logic              hit;

        assign hit = wr_apply && (w_idx == 32'(gi));

        // merge strobed bytes on commit; pulse follows the commit edge
        always_ff @(posedge axi_clk or posedge axi_rst) begin
            if (axi_rst) begin
                q_reg     <= RW_RST_VAL[gi*DATA_W +: DATA_W];
                pulse_reg <= 1'b0;
            end else begin
                pulse_reg <= hit;
                if (hit)
                    q_reg <= (q_reg & ~wr_mask) | (wdata_reg & wr_mask);
            end
        end

        assign rw_q[gi*DATA_W +: DATA_W] = q_reg;
        assign wr_pulse[gi]              = pulse_reg;
    end

    // AW/W capture, commit response and B handshake
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            aw_held_reg <= 1'b0;
            w_held_reg  <= 1'b0;
            bvalid_reg  <= 1'b0;
            bresp_reg   <= RESP_OKAY;
            aw_idx_reg  <= '0;
            wdata_reg   <= '0;
            wstrb_reg   <= '0;
        end else begin
            if (aw_hs) begin
                aw_held_reg <= 1'b1;
                aw_idx_reg  <= axi_awaddr[ADDR_W-1:LSB];
            end
            if (w_hs) begin
                w_held_reg <= 1'b1;
                wdata_reg  <= axi_wdata;
                wstrb_reg  <= axi_wstrb;
            end
            if (wr_commit) begin
                bvalid_reg <= 1'b1;
                bresp_reg  <= wr_resp_next;
            end else if (b_hs) begin
                bvalid_reg  <= 1'b0;
                aw_held_reg <= 1'b0;
                w_held_reg  <= 1'b0;
            end
        end
    end

    // read data mux and read-only access strobes for the incoming address
    always_comb begin
        rd_data_next  = '0;
        rd_resp_next  = (r_is_rw || r_is_ro) ? RESP_OKAY : RESP_DECERR;
        rd_pulse_next = '0;
        for (int k = 0; k < N_RW; k++) begin
            if (r_idx == 32'(k))
                rd_data_next = rw_q[k*DATA_W +: DATA_W];
        end
        for (int k = 0; k < N_RO; k++) begin
            if (r_idx == 32'(N_RW + k)) begin
                rd_data_next     = ro_d[k*DATA_W +: DATA_W];
                rd_pulse_next[k] = ar_hs;
            end
        end
    end

    // AR handshake latches the response; R handshake releases it
    always_ff @(posedge axi_clk or posedge axi_rst) begin
        if (axi_rst) begin
            rvalid_reg   <= 1'b0;
            rdata_reg    <= '0;
            rresp_reg    <= RESP_OKAY;
            rd_pulse_reg <= '0;
        end else begin
            rd_pulse_reg <= rd_pulse_next;
            if (ar_hs) begin
                rvalid_reg <= 1'b1;
                rdata_reg  <= rd_data_next;
                rresp_reg  <= rd_resp_next;
            end else if (rvalid_reg && axi_rready) begin
                rvalid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axil_regbank.sv
// Testbench for axil_regbank: directed scenarios with literal expectations
// plus a randomized phase, all shadowed by a transaction-level model that is
// compared against every DUT output on every falling clock edge.
module tb_axil_regbank;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int NRW = 8;
    localparam int NRO = 8;
    localparam int BOUND = 64;
    localparam logic [NRW*DW-1:0] RST_IMG = {
        32'hA5A5_0007, 32'hA5A5_0006, 32'hA5A5_0005, 32'hA5A5_0004,
        32'hA5A5_0003, 32'hA5A5_0002, 32'hA5A5_0001, 32'hA5A5_0000};

    logic axi_clk = 1'b0;
    logic axi_rst = 1'b0;
    logic [AW-1:0] axi_awaddr = '0;
    logic [2:0]    axi_awprot = '0;
    logic          axi_awvalid = 1'b0;
    logic          axi_awready;
    logic [DW-1:0] axi_wdata = '0;
    logic [3:0]    axi_wstrb = '0;
    logic          axi_wvalid = 1'b0;
    logic          axi_wready;
    logic [1:0]    axi_bresp;
    logic          axi_bvalid;
    logic          axi_bready = 1'b0;
    logic [AW-1:0] axi_araddr = '0;
    logic [2:0]    axi_arprot = '0;
    logic          axi_arvalid = 1'b0;
    logic          axi_arready;
    logic [DW-1:0] axi_rdata;
    logic [1:0]    axi_rresp;
    logic          axi_rvalid;
    logic          axi_rready = 1'b0;
    logic [NRW*DW-1:0] rw_q;
    logic [NRW-1:0]    wr_pulse;
    logic [NRO*DW-1:0] ro_d = '0;
    logic [NRO-1:0]    rd_pulse;

    axil_regbank #(
        .DATA_W(DW), .ADDR_W(AW), .N_RW(NRW), .N_RO(NRO), .RW_RST_VAL(RST_IMG)
    ) dut (
        .axi_clk(axi_clk), .axi_rst(axi_rst),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
        .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .rw_q(rw_q), .wr_pulse(wr_pulse), .ro_d(ro_d), .rd_pulse(rd_pulse)
    );

    always #5 axi_clk = ~axi_clk;

    int n_checks = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic timeout(input string name);
        n_checks++;
        $display("FAIL %s: no handshake within %0d cycles, expected one (t=%0t)", name, BOUND, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]    m_rw [NRW];
    bit             m_awh, m_wh, m_bv, m_rv;
    logic [1:0]     m_bresp, m_rresp;
    logic [31:0]    m_rdata, m_wdata;
    logic [15:0]    m_awaddr;
    logic [3:0]     m_wstrb;
    logic [NRW-1:0] m_wrp;
    logic [NRO-1:0] m_rdp;

    task automatic model_reset();
        for (int k = 0; k < NRW; k++) m_rw[k] = RST_IMG[k*32 +: 32];
        m_awh = 0; m_wh = 0; m_bv = 0; m_rv = 0;
        m_bresp = 0; m_rresp = 0; m_rdata = 0;
        m_wrp = '0; m_rdp = '0;
    endtask

    task automatic model_step();
        bit awrdy, wrdy, arrdy, commit, ok;
        int idx;
        awrdy  = !m_awh && !m_bv;
        wrdy   = !m_wh && !m_bv;
        arrdy  = !m_rv;
        commit = m_awh && m_wh && !m_bv;
        m_wrp = '0;
        m_rdp = '0;
        // reads see register contents from before this edge
        if (axi_arvalid && arrdy) begin
            idx = int'(axi_araddr) / 4;
            m_rv = 1;
            if (idx < NRW) begin
                m_rdata = m_rw[idx]; m_rresp = 2'b00;
            end else if (idx < NRW + NRO) begin
                m_rdata = ro_d[(idx-NRW)*32 +: 32]; m_rresp = 2'b00; m_rdp[idx-NRW] = 1'b1;
            end else begin
                m_rdata = 0; m_rresp = 2'b11;
            end
        end else if (m_rv && axi_rready) begin
            m_rv = 0;
        end
        if (commit) begin
            idx = int'(m_awaddr) / 4;
            m_bv = 1;
            if (idx < NRW) begin
`ifdef AXIL_REGBANK_STRB_EN
                ok = 1;
`else
                ok = (m_wstrb == 4'hF);
`endif
                if (ok) begin
                    for (int b = 0; b < 4; b++)
                        if (m_wstrb[b]) m_rw[idx][b*8 +: 8] = m_wdata[b*8 +: 8];
                    m_wrp[idx] = 1'b1;
                    m_bresp = 2'b00;
                end else begin
                    m_bresp = 2'b10;
                end
            end else if (idx < NRW + NRO) begin
                m_bresp = 2'b10;
            end else begin
                m_bresp = 2'b11;
            end
        end else if (m_bv && axi_bready) begin
            m_bv = 0; m_awh = 0; m_wh = 0;
        end
        if (axi_awvalid && awrdy) begin m_awh = 1; m_awaddr = axi_awaddr; end
        if (axi_wvalid && wrdy) begin m_wh = 1; m_wdata = axi_wdata; m_wstrb = axi_wstrb; end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge axi_clk or posedge axi_rst);
            if (axi_rst) model_reset();
            else model_step();
        end
    end

    // compare every DUT output against the model on each falling edge
    initial begin
        forever begin
            @(negedge axi_clk);
            check("awready", axi_awready, !m_awh && !m_bv);
            check("wready", axi_wready, !m_wh && !m_bv);
            check("arready", axi_arready, !m_rv);
            check("bvalid", axi_bvalid, m_bv);
            if (m_bv) check("bresp", axi_bresp, m_bresp);
            check("rvalid", axi_rvalid, m_rv);
            if (m_rv) begin
                check("rdata", axi_rdata, m_rdata);
                check("rresp", axi_rresp, m_rresp);
            end
            for (int k = 0; k < NRW; k++)
                check($sformatf("rw_q[%0d]", k), rw_q[k*32 +: 32], m_rw[k]);
            check("wr_pulse", wr_pulse, m_wrp);
            check("rd_pulse", rd_pulse, m_rdp);
        end
    end

    // running pulse counters for the directed single-pulse checks
    int wr_cnt = 0;
    int rd0_cnt = 0;
    initial begin
        forever begin
            @(negedge axi_clk);
            wr_cnt += $countones(wr_pulse);
            rd0_cnt += int'(rd_pulse[0]);
        end
    end

    // ---------------- drivers (all changes at posedge + 1) ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge axi_clk); #1; end
    endtask

    task automatic drive_aw(input logic [15:0] a, input int dly);
        bit r; int n;
        cyc(dly);
        axi_awaddr = a; axi_awvalid = 1'b1; n = 0;
        forever begin
            r = axi_awready; cyc(1); n++;
            if (r) break;
            if (n > BOUND) begin timeout("aw_handshake"); break; end
        end
        axi_awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        bit r; int n;
        cyc(dly);
        axi_wdata = d; axi_wstrb = s; axi_wvalid = 1'b1; n = 0;
        forever begin
            r = axi_wready; cyc(1); n++;
            if (r) break;
            if (n > BOUND) begin timeout("w_handshake"); break; end
        end
        axi_wvalid = 1'b0;
    endtask

    task automatic drive_ar(input logic [15:0] a, input int dly);
        bit r; int n;
        cyc(dly);
        axi_araddr = a; axi_arvalid = 1'b1; n = 0;
        forever begin
            r = axi_arready; cyc(1); n++;
            if (r) break;
            if (n > BOUND) begin timeout("ar_handshake"); break; end
        end
        axi_arvalid = 1'b0;
    endtask

    task automatic finish_b(input int dly, output logic [1:0] resp);
        int n = 0;
        while (!axi_bvalid && n <= BOUND) begin cyc(1); n++; end
        if (!axi_bvalid) begin timeout("bvalid"); resp = 2'bxx; return; end
        cyc(dly);
        resp = axi_bresp;
        axi_bready = 1'b1; cyc(1); axi_bready = 1'b0;
    endtask

    task automatic finish_r(input int dly, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        while (!axi_rvalid && n <= BOUND) begin cyc(1); n++; end
        if (!axi_rvalid) begin timeout("rvalid"); data = 'x; resp = 2'bxx; return; end
        cyc(dly);
        data = axi_rdata; resp = axi_rresp;
        axi_rready = 1'b1; cyc(1); axi_rready = 1'b0;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd, output logic [1:0] resp);
        fork
            drive_aw(a, awd);
            drive_w(d, s, wd);
        join
        finish_b(bd, resp);
    endtask

    task automatic do_read(input logic [15:0] a, input int ad, input int rd,
                           output logic [31:0] data, output logic [1:0] resp);
        drive_ar(a, ad);
        finish_r(rd, data, resp);
    endtask

    function automatic logic [15:0] rand_addr();
        int cat = $urandom_range(0, 9);
        logic [15:0] lo = 16'($urandom_range(0, 3));
        if (cat < 5) return 16'($urandom_range(0, NRW-1) * 4) | lo;
        if (cat < 8) return 16'((NRW + $urandom_range(0, NRO-1)) * 4) | lo;
        return 16'($urandom_range(NRW + NRO, 16383) * 4) | lo;
    endfunction

    bit rand_phase = 1'b0;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1);
    end

    // ---------------- directed scenarios, then random traffic ----------------
    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        int c0;

        #1 axi_rst = 1'b1;
        cyc(3);
        axi_rst = 1'b0;

        // reset state
        check("rst_awready", axi_awready, 1);
        check("rst_wready", axi_wready, 1);
        check("rst_arready", axi_arready, 1);
        check("rst_bvalid", axi_bvalid, 0);
        check("rst_rvalid", axi_rvalid, 0);
        check("rst_bresp", axi_bresp, 0);
        check("rst_rresp", axi_rresp, 0);
        check("rst_rdata", axi_rdata, 0);
        check("rst_pulses", {wr_pulse, rd_pulse}, 0);
        for (int k = 0; k < NRW; k++)
            check($sformatf("rst_rw_q[%0d]", k), rw_q[k*32 +: 32], 32'hA5A5_0000 + 32'(k));

        // AW first, W three cycles later
        c0 = wr_cnt;
        drive_aw(16'h0008, 0);
        cyc(3);
        drive_w(32'hDEADBEEF, 4'hF, 0);
        check("aw_blocked", axi_awready, 0);
        check("rw2_before_commit", rw_q[2*32 +: 32], 32'hA5A5_0002);
        cyc(1);
        check("rw2_after_commit", rw_q[2*32 +: 32], 32'hDEADBEEF);
        check("wr_pulse_commit", wr_pulse, 8'h04);
        check("bvalid_commit", axi_bvalid, 1);
        cyc(1);
        check("wr_pulse_gone", wr_pulse, 0);
        finish_b(0, r);
        check("bresp_0x08", r, 2'b00);
        check("wr_pulse_count_0x08", wr_cnt - c0, 1);
        do_read(16'h0008, 0, 0, d, r);
        check("rdata_0x08", d, 32'hDEADBEEF);
        check("rresp_0x08", r, 2'b00);

        // partial-strobe write
        do_write(16'h000C, 32'h11223344, 4'hF, 0, 0, 0, r);
        check("bresp_0x0C_full", r, 2'b00);
        do_write(16'h000C, 32'hAABBCCDD, 4'h5, 0, 1, 0, r);
`ifdef AXIL_REGBANK_STRB_EN
        check("bresp_0x0C_part", r, 2'b00);
        check("rw3_merged", rw_q[3*32 +: 32], 32'h11BB33DD);
`else
        check("bresp_0x0C_part", r, 2'b10);
        check("rw3_kept", rw_q[3*32 +: 32], 32'h11223344);
`endif

        // read-only register held under back-pressure
        ro_d[31:0] = 32'h00C0FFEE;
        c0 = rd0_cnt;
        drive_ar(16'h0020, 0);
        ro_d[31:0] = 32'h0BAD0BAD;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("ro_hold_rvalid", axi_rvalid, 1);
            check("ro_hold_rdata", axi_rdata, 32'h00C0FFEE);
            check("ro_hold_rresp", axi_rresp, 2'b00);
        end
        axi_rready = 1'b1; cyc(1); axi_rready = 1'b0;
        check("ro_rvalid_dropped", axi_rvalid, 0);
        check("rd_pulse0_count", rd0_cnt - c0, 1);
        c0 = wr_cnt;
        do_write(16'h0020, 32'h12345678, 4'hF, 1, 0, 0, r);
        check("bresp_ro", r, 2'b10);
        check("wr_pulse_count_ro", wr_cnt - c0, 0);

        // unmapped
        do_read(16'h0100, 0, 0, d, r);
        check("rdata_unmapped", d, 0);
        check("rresp_unmapped", r, 2'b11);
        c0 = wr_cnt;
        do_write(16'h0100, 32'hFFFFFFFF, 4'hF, 0, 0, 2, r);
        check("bresp_unmapped", r, 2'b11);
        check("wr_pulse_count_unmapped", wr_cnt - c0, 0);

        // W before AW, read accepted on the commit edge
        drive_w(32'h12345678, 4'hF, 0);
        drive_aw(16'h0000, 0);
        drive_ar(16'h0000, 0);
        check("race_rvalid", axi_rvalid, 1);
        check("race_rdata_old", axi_rdata, 32'hA5A5_0000);
        check("race_rw0_new", rw_q[31:0], 32'h12345678);
        axi_rready = 1'b1; cyc(1); axi_rready = 1'b0;
        finish_b(0, r);
        check("race_bresp", r, 2'b00);
        do_read(16'h0000, 0, 0, d, r);
        check("race_rdata_new", d, 32'h12345678);

        // reset while a response is pending
        fork
            drive_aw(16'h0004, 0);
            drive_w(32'h00000001, 4'hF, 0);
        join
        cyc(1);
        check("pre_rst_bvalid", axi_bvalid, 1);
        check("pre_rst_rw1", rw_q[63:32], 32'h00000001);
        axi_rst = 1'b1;
        #1;
        check("mid_rst_bvalid", axi_bvalid, 0);
        check("mid_rst_rw1", rw_q[63:32], 32'hA5A5_0001);
        check("mid_rst_rw0", rw_q[31:0], 32'hA5A5_0000);
        check("mid_rst_awready", axi_awready, 1);
        check("mid_rst_wr_pulse", wr_pulse, 0);
        cyc(2);
        axi_rst = 1'b0;
        cyc(1);

        // randomized traffic on both channels concurrently
        rand_phase = 1'b1;
        fork
            begin
                fork
                    for (int i = 0; i < 150; i++) begin
                        logic [1:0] wr_r;
                        logic [3:0] s = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom);
                        do_write(rand_addr(), $urandom, s, $urandom_range(0, 3),
                                 $urandom_range(0, 3), $urandom_range(0, 2), wr_r);
                    end
                    for (int i = 0; i < 150; i++) begin
                        logic [31:0] rd_d;
                        logic [1:0]  rd_r;
                        do_read(rand_addr(), $urandom_range(0, 3), $urandom_range(0, 3), rd_d, rd_r);
                    end
                join
                rand_phase = 1'b0;
            end
            while (rand_phase || n_checks == 0) begin
                cyc(1);
                for (int k = 0; k < NRO; k++) ro_d[k*32 +: 32] = $urandom;
            end
        join

        cyc(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
